// File: rtl/rotor_stepper.sv
// Enigma-style rotor position stepper: advances right/middle/left positions once per accepted
// keypress (including the middle-rotor double step) and holds them until downstream consumes them.
module rotor_stepper #(
    parameter int NOTCH_R = 21,
    parameter int NOTCH_M = 4,
    parameter int NUM_POS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [4:0]  init_l,
    input  logic [4:0]  init_m,
    input  logic [4:0]  init_r,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        pos_valid,
    input  logic        pos_ready,
    output logic        load_err,
    output logic [15:0] key_count
);

    // state   | meaning
    // IDLE    | waiting for a keypress, key_ready=1
    // PRESENT | post-step positions held for downstream, pos_valid=1
    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  pos_l_q, pos_l_d;
    logic [4:0]  pos_m_q, pos_m_d;
    logic [4:0]  pos_r_q, pos_r_d;
    logic        load_err_q, load_err_d;
    logic [15:0] key_count_q, key_count_d;
    logic        accept;
    logic        bad_l, bad_m, bad_r;

    // 6-bit sum so that 25+1 is seen as 26 and wraps to 0
    function automatic logic [4:0] step_pos(input logic [4:0] p);
        logic [5:0] s;
        s = {1'b0, p} + 6'd1;
        if (s >= 6'(NUM_POS)) s = 6'd0;
        return s[4:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_l_q     <= '0;
            pos_m_q     <= '0;
            pos_r_q     <= '0;
            load_err_q  <= 1'b0;
            key_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_l_q     <= pos_l_d;
            pos_m_q     <= pos_m_d;
            pos_r_q     <= pos_r_d;
            load_err_q  <= load_err_d;
            key_count_q <= key_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (key_valid) state_d = PRESENT;
                PRESENT: if (pos_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        key_ready = (state_q == IDLE);
        pos_valid = (state_q == PRESENT);
    end

    assign accept = (state_q == IDLE) && key_valid && !load;
    assign bad_l  = ({1'b0, init_l} >= 6'(NUM_POS));
    assign bad_m  = ({1'b0, init_m} >= 6'(NUM_POS));
    assign bad_r  = ({1'b0, init_r} >= 6'(NUM_POS));

    // Notch decisions look only at the pre-step positions
    always_comb begin
        pos_l_d     = pos_l_q;
        pos_m_d     = pos_m_q;
        pos_r_d     = pos_r_q;
        load_err_d  = load_err_q;
        key_count_d = key_count_q;
        if (load) begin
            pos_l_d     = bad_l ? 5'd0 : init_l;
            pos_m_d     = bad_m ? 5'd0 : init_m;
            pos_r_d     = bad_r ? 5'd0 : init_r;
            load_err_d  = bad_l || bad_m || bad_r;
            key_count_d = '0;
        end else if (accept) begin
            pos_r_d = step_pos(pos_r_q);
            if ((pos_r_q == 5'(NOTCH_R)) || (pos_m_q == 5'(NOTCH_M)))
                pos_m_d = step_pos(pos_m_q);
            if (pos_m_q == 5'(NOTCH_M))
                pos_l_d = step_pos(pos_l_q);
            key_count_d = key_count_q + 16'd1;
        end
    end

    assign pos_l     = pos_l_q;
    assign pos_m     = pos_m_q;
    assign pos_r     = pos_r_q;
    assign load_err  = load_err_q;
    assign key_count = key_count_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: reset, stepping incl. double step and wrap, backpressure,
// load clamping/error, and rst/load priority while positions are presented.
module tb_rotor_stepper;

    logic        clk = 1'b0;
    logic        rst, load, key_valid, pos_ready;
    logic [4:0]  init_l, init_m, init_r;
    logic        key_ready, pos_valid, load_err;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic [15:0] key_count;

    int n_checks = 0;
    int n_errors = 0;

    rotor_stepper dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .init_l    (init_l),
        .init_m    (init_m),
        .init_r    (init_r),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .pos_l     (pos_l),
        .pos_m     (pos_m),
        .pos_r     (pos_r),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .load_err  (load_err),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_pos(input string tag, input int l, input int m, input int r);
        check(tag, {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'(l), 5'(m), 5'(r)});
    endtask

    task automatic do_load(input int l, input int m, input int r);
        load   = 1'b1;
        init_l = 5'(l);
        init_m = 5'(m);
        init_r = 5'(r);
        tick();
        load   = 1'b0;
        init_l = '0;
        init_m = '0;
        init_r = '0;
    endtask

    // One keypress with immediate consumption; checks the presented positions
    task automatic key_step(input string tag, input int l, input int m, input int r);
        key_valid = 1'b1;
        pos_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        check_pos(tag, l, m, r);
        check({tag, "_pv"}, 32'(pos_valid), 32'd1);
        check({tag, "_kr0"}, 32'(key_ready), 32'd0);
        tick();
        check({tag, "_kr1"}, 32'(key_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; key_valid = 1'b0; pos_ready = 1'b0;
        init_l = '0; init_m = '0; init_r = '0;
        @(negedge clk);

        // reset
        tick(); tick();
        rst = 1'b0;
        check_pos("rst_pos", 0, 0, 0);
        check("rst_pv", 32'(pos_valid), 32'd0);
        check("rst_kr", 32'(key_ready), 32'd1);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_cnt", 32'(key_count), 32'd0);

        // ADU -> ADV, AEW, BFX
        do_load(0, 3, 20);
        check_pos("load_adu", 0, 3, 20);
        key_step("k_adv", 0, 3, 21);
        key_step("k_aew", 0, 4, 22);
        key_step("k_bfx", 1, 5, 23);
        check("cnt3", 32'(key_count), 32'd3);

        // wraps
        do_load(0, 0, 25);
        check("cnt_clr", 32'(key_count), 32'd0);
        key_step("wrap_r", 0, 0, 0);
        do_load(25, 4, 0);
        key_step("wrap_l", 0, 5, 1);
        check("cnt1", 32'(key_count), 32'd1);

        // backpressure with key_valid held
        key_valid = 1'b1;
        pos_ready = 1'b0;
        tick();
        check_pos("bp_step", 0, 5, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pos("bp_hold", 0, 5, 2);
            check("bp_pv", 32'(pos_valid), 32'd1);
            check("bp_kr", 32'(key_ready), 32'd0);
        end
        check("bp_cnt", 32'(key_count), 32'd2);
        key_valid = 1'b0;
        pos_ready = 1'b1;
        tick();
        check("bp_idle_kr", 32'(key_ready), 32'd1);
        check("bp_idle_pv", 32'(pos_valid), 32'd0);
        key_step("bp_next", 0, 5, 3);
        check("bp_cnt3", 32'(key_count), 32'd3);

        // out-of-range load
        do_load(27, 3, 31);
        check_pos("err_pos", 0, 3, 0);
        check("err_set", 32'(load_err), 32'd1);
        key_step("err_step", 0, 3, 1);
        check("err_sticky", 32'(load_err), 32'd1);
        do_load(1, 2, 3);
        check_pos("ok_pos", 1, 2, 3);
        check("err_clr", 32'(load_err), 32'd0);

        // rst in PRESENT
        key_valid = 1'b1;
        pos_ready = 1'b0;
        tick();
        key_valid = 1'b0;
        check_pos("pr_step", 1, 2, 4);
        check("pr_pv", 32'(pos_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_pos("pr_rst_pos", 0, 0, 0);
        check("pr_rst_pv", 32'(pos_valid), 32'd0);
        check("pr_rst_kr", 32'(key_ready), 32'd1);
        check("pr_rst_cnt", 32'(key_count), 32'd0);

        // load with key_valid in PRESENT
        key_valid = 1'b1;
        tick();
        check_pos("pl_step", 0, 0, 1);
        load = 1'b1;
        init_l = 5'd5; init_m = 5'd6; init_r = 5'd7;
        tick();
        load = 1'b0;
        key_valid = 1'b0;
        check_pos("pl_pos", 5, 6, 7);
        check("pl_pv", 32'(pos_valid), 32'd0);
        check("pl_kr", 32'(key_ready), 32'd1);
        check("pl_cnt", 32'(key_count), 32'd0);

        // load in IDLE with key_valid also ignores the key
        key_valid = 1'b1;
        load = 1'b1;
        init_l = 5'd9; init_m = 5'd9; init_r = 5'd9;
        tick();
        load = 1'b0;
        key_valid = 1'b0;
        check_pos("il_pos", 9, 9, 9);
        check("il_pv", 32'(pos_valid), 32'd0);
        check("il_cnt", 32'(key_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
